// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first, carry held in a flip-flop.
// Latency: start edge to done is N edges; start is only accepted in IDLE, with no queuing.
module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   s_sr;
    logic           c;
    logic [CW-1:0]  cnt;

    logic           fa_sum;
    logic           fa_carry;

    // The shared full-adder cell.
    assign fa_sum   = a_sr[0] ^ b_sr[0] ^ c;
    assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        c     <= Cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_sr <= {fa_sum, s_sr[N-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= fa_carry;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        // c is the carry into the MSB here, so c ^ carry-out is signed overflow.
                        S     <= {fa_sum, s_sr[N-1:1]};
                        Cout  <= fa_carry;
                        V     <= c ^ fa_carry;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int N = 8;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         Cout;
    logic         V;

    int tests = 0;
    int fails = 0;

    serial_add_ctrl #(.N(N)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .V     (V)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {V, Cout, S} for A + B + Cin.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        logic [N:0] sum;
        logic       v;
        sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        return {v, sum};
    endfunction

    // Issues one start; when inj >= 0 a second start with other operands is pulsed mid-run.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input logic [N-1:0] exp_s, input logic exp_c,
                         input logic exp_v, input int inj);
        int edges;
        int busy_cnt;
        A = a; B = b; Cin = cin; start = 1'b1;
        tick;
        start = 1'b0;
        edges = 0;
        busy_cnt = 0;
        while (!done && edges < 3 * N) begin
            if (busy) busy_cnt++;
            if (edges == inj) begin
                start = 1'b1; A = 8'h11; B = 8'h22; Cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick;
            edges++;
        end
        start = 1'b0;
        check({tag, " latency"}, edges, N);
        check({tag, " busy_cycles"}, busy_cnt, N);
        check({tag, " done"}, {31'd0, done}, 1);
        check({tag, " busy_at_done"}, {31'd0, busy}, 0);
        check({tag, " S"}, {24'd0, S}, {24'd0, exp_s});
        check({tag, " Cout"}, {31'd0, Cout}, {31'd0, exp_c});
        check({tag, " V"}, {31'd0, V}, {31'd0, exp_v});
        tick;
        check({tag, " done_one_cycle"}, {31'd0, done}, 0);
    endtask

    initial begin
        int dcnt;
        int dpos[3];
        int unstable;
        int guard;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic [N+1:0] exp;

        RST = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        tick;
        tick;
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset S", {24'd0, S}, 0);
        check("reset Cout", {31'd0, Cout}, 0);
        check("reset V", {31'd0, V}, 0);
        RST = 1'b0;
        tick;

        do_op("5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, -1);
        do_op("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
        do_op("7F+00+1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, -1);
        do_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);

        // A start pulse during SHIFT must not disturb or queue anything.
        do_op("midstart", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 3);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done || busy) dcnt++;
        end
        check("midstart no_requeue", dcnt, 0);

        // start held high: one completion every N+2 cycles.
        A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
        tick;
        dcnt = 0;
        unstable = 0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            tick;
            if (done) begin
                if (dcnt < 3) dpos[dcnt] = cyc;
                dcnt++;
            end
            if (cyc >= N && S !== 8'h02) unstable++;
        end
        start = 1'b0;
        check("held done_count", dcnt, 3);
        check("held done_pos0", dpos[0], N);
        check("held done_pos1", dpos[1], N + 10);
        check("held done_pos2", dpos[2], N + 20);
        check("held S_stable", unstable, 0);
        guard = 0;
        while (!done && guard < 3 * N) begin
            tick;
            guard++;
        end
        check("held drain", {31'd0, done}, 1);
        tick;

        // Reset in the 4th SHIFT cycle aborts and clears the result.
        A = 8'h5A; B = 8'h3C; Cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        check("abort busy_before", {31'd0, busy}, 1);
        RST = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 0);
        check("abort done", {31'd0, done}, 0);
        check("abort S", {24'd0, S}, 0);
        check("abort Cout", {31'd0, Cout}, 0);
        check("abort V", {31'd0, V}, 0);
        tick;
        RST = 1'b0;
        tick;
        check("abort idle", {30'd0, busy, done}, 0);
        do_op("after_abort", 8'hC8, 8'h9C, 1'b1, 8'h65, 1'b1, 1'b1, -1);

        for (int i = 0; i < 200; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            exp = model(ra, rb, rc);
            do_op("random", ra, rb, rc, exp[N-1:0], exp[N], exp[N+1], -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
